ram_access_arbiter: RTL and testbench

- Shares the processor's single-port data/instruction RAM between two requesters: the CPU core (control-unit fetch/data accesses) and the program loader (a DMA-style port that fills RAM before or while the CPU runs).
- Sequences each access as a multi-cycle transaction: arbitrate, drive RAM, wait for read latency, acknowledge.
- Sits between the datapath's memory interface and the RAM macro, replacing the direct RAM connection.

---
 rtl/ram_access_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Shares one single-port RAM between the CPU core and the program loader.
//   Every access runs as a short transaction: IDLE (arbitrate) -> ACCESS
//   (drive RAM for one cycle) -> WAIT (reads only, READ_LATENCY cycles) ->
//   ACK (one-cycle completion pulse to the owner).
//
// Ports
//   CLOCK, RESET                 clock, synchronous active-high reset
//   CPU_REQ/WE/ADDR/WDATA        CPU request, held until CPU_ACK
//   CPU_RDATA, CPU_ACK           CPU read data (valid with ACK) and done pulse
//   CPU_STALL                    CPU_REQ & ~CPU_ACK
//   LD_REQ/WE/ADDR/WDATA         loader request, held until LD_ACK
//   LD_RDATA, LD_ACK             loader read data and done pulse
//   LD_LOCK                      blocks new CPU grants while high
//   RAM_EN/WE/ADDR/WDATA         RAM macro control, address and write data
//   RAM_RDATA                    RAM macro read data
//   BUSY                         high whenever the arbiter is not IDLE
module ram_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ACK,
  output logic              CPU_STALL,
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  output logic [DATA_W-1:0] LD_RDATA,
  output logic              LD_ACK,
  input  logic              LD_LOCK,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic [2:0] LP_LAT = 3'(READ_LATENCY);

  state_t            r_state;
  logic              r_owner_ld;   // 1 = loader owns the current transaction
  logic              r_last_ld;    // 1 = loader was granted last (CPU wins a tie)
  logic [2:0]        r_cnt;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              r_cpu_ack;
  logic              r_ld_ack;

  logic              w_cpu_elig;
  logic              w_ld_elig;
  logic              w_grant_any;
  logic              w_grant_ld;

  // Eligibility and round-robin tie-break, evaluated only in IDLE
  always_comb begin
    w_cpu_elig  = CPU_REQ & ~LD_LOCK;
    w_ld_elig   = LD_REQ;
    w_grant_any = w_cpu_elig | w_ld_elig;
    w_grant_ld  = w_ld_elig & (~w_cpu_elig | ~r_last_ld);
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_owner_ld  <= 1'b0;
      r_last_ld   <= 1'b1;
      r_cnt       <= 3'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
      r_cpu_ack   <= 1'b0;
      r_ld_ack    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_owner_ld  <= w_grant_ld;
            r_last_ld   <= w_grant_ld;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_grant_ld ? LD_WE    : CPU_WE;
            r_ram_addr  <= w_grant_ld ? LD_ADDR  : CPU_ADDR;
            r_ram_wdata <= w_grant_ld ? LD_WDATA : CPU_WDATA;
            r_state     <= S_ACCESS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          // r_ram_we still holds the granted direction during this cycle
          if (r_ram_we) begin
            r_cpu_ack <= ~r_owner_ld;
            r_ld_ack  <= r_owner_ld;
            r_state   <= S_ACK;
          end else begin
            r_cnt   <= LP_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd1) begin
            // RAM_RDATA is valid in the last WAIT cycle
            if (r_owner_ld) begin
              r_ld_rdata <= RAM_RDATA;
            end else begin
              r_cpu_rdata <= RAM_RDATA;
            end
            r_cpu_ack <= ~r_owner_ld;
            r_ld_ack  <= r_owner_ld;
            r_cnt     <= 3'd0;
            r_state   <= S_ACK;
          end else begin
            r_cnt   <= r_cnt - 3'd1;
            r_state <= S_WAIT;
          end
        end
        S_ACK: begin
          r_cpu_ack <= 1'b0;
          r_ld_ack  <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_ram_en  <= 1'b0;
          r_ram_we  <= 1'b0;
          r_cpu_ack <= 1'b0;
          r_ld_ack  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign RAM_EN    = r_ram_en;
  assign RAM_WE    = r_ram_we;
  assign RAM_ADDR  = r_ram_addr;
  assign RAM_WDATA = r_ram_wdata;
  assign CPU_RDATA = r_cpu_rdata;
  assign LD_RDATA  = r_ld_rdata;
  assign CPU_ACK   = r_cpu_ack;
  assign LD_ACK    = r_ld_ack;
  assign CPU_STALL = CPU_REQ & ~r_cpu_ack;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: main instance (READ_LATENCY=1) checked
// through an ACK scoreboard plus inline cycle checks, and a second instance
// with READ_LATENCY=3 for the long-latency read.
module tb_ram_access_arbiter;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [7:0] CPU_ADDR = 8'h00, CPU_WDATA = 8'h00;
  logic [7:0] CPU_RDATA;
  logic       CPU_ACK, CPU_STALL;
  logic       LD_REQ = 1'b0, LD_WE = 1'b0, LD_LOCK = 1'b0;
  logic [7:0] LD_ADDR = 8'h00, LD_WDATA = 8'h00;
  logic [7:0] LD_RDATA;
  logic       LD_ACK;
  logic       RAM_EN, RAM_WE, BUSY;
  logic [7:0] RAM_ADDR, RAM_WDATA, RAM_RDATA;

  // second instance, READ_LATENCY=3, CPU side idle
  logic       CPU_REQ3 = 1'b0, CPU_WE3 = 1'b0;
  logic [7:0] CPU_ADDR3 = 8'h00, CPU_WDATA3 = 8'h00;
  logic [7:0] CPU_RDATA3;
  logic       CPU_ACK3, CPU_STALL3;
  logic       LD_REQ3 = 1'b0, LD_WE3 = 1'b0, LD_LOCK3 = 1'b0;
  logic [7:0] LD_ADDR3 = 8'h00, LD_WDATA3 = 8'h00;
  logic [7:0] LD_RDATA3;
  logic       LD_ACK3;
  logic       RAM_EN3, RAM_WE3, BUSY3;
  logic [7:0] RAM_ADDR3, RAM_WDATA3, RAM_RDATA3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit       ld;
    bit       rd;
    bit [7:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK), .CPU_STALL(CPU_STALL),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_RDATA(LD_RDATA), .LD_ACK(LD_ACK), .LD_LOCK(LD_LOCK),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA), .BUSY(BUSY)
  );

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
    .CLOCK(CLOCK), .RESET(RESET),
    .CPU_REQ(CPU_REQ3), .CPU_WE(CPU_WE3), .CPU_ADDR(CPU_ADDR3), .CPU_WDATA(CPU_WDATA3),
    .CPU_RDATA(CPU_RDATA3), .CPU_ACK(CPU_ACK3), .CPU_STALL(CPU_STALL3),
    .LD_REQ(LD_REQ3), .LD_WE(LD_WE3), .LD_ADDR(LD_ADDR3), .LD_WDATA(LD_WDATA3),
    .LD_RDATA(LD_RDATA3), .LD_ACK(LD_ACK3), .LD_LOCK(LD_LOCK3),
    .RAM_EN(RAM_EN3), .RAM_WE(RAM_WE3), .RAM_ADDR(RAM_ADDR3), .RAM_WDATA(RAM_WDATA3),
    .RAM_RDATA(RAM_RDATA3), .BUSY(BUSY3)
  );

  always #5 CLOCK = ~CLOCK;

  // RAM model, latency 1
  logic [7:0] mem [256];
  logic [7:0] rd_pipe;
  always @(posedge CLOCK) begin
    if (RAM_EN && RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_EN && !RAM_WE) rd_pipe <= mem[RAM_ADDR];
  end
  assign RAM_RDATA = rd_pipe;

  // RAM model, latency 3; contents are addr ^ 0x18
  logic [7:0] p3_0, p3_1, p3_2;
  always @(posedge CLOCK) begin
    p3_0 <= (RAM_EN3 && !RAM_WE3) ? (RAM_ADDR3 ^ 8'h18) : 8'h00;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign RAM_RDATA3 = p3_2;

  // Scoreboard: every ACK of the main instance must match the next expectation
  always @(negedge CLOCK) begin
    if (!RESET && (CPU_ACK || LD_ACK)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ack: cpu_ack=%0b ld_ack=%0b, required no ack", CPU_ACK, LD_ACK);
      end else begin
        sb_e = sb_q.pop_front();
        if ((CPU_ACK && LD_ACK) || (LD_ACK !== sb_e.ld) ||
            (sb_e.rd && ((sb_e.ld ? LD_RDATA : CPU_RDATA) !== sb_e.data))) begin
          n_err++;
          $display("FAIL sb_ack: cpu_ack=%0b ld_ack=%0b cpu_rd=%h ld_rd=%h, required owner_ld=%0b rd=%0b data=%h",
                   CPU_ACK, LD_ACK, CPU_RDATA, LD_RDATA, sb_e.ld, sb_e.rd, sb_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic push(input bit ld, input bit rd, input bit [7:0] data);
    exp_t e;
    e.ld = ld; e.rd = rd; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({CPU_ACK, LD_ACK, RAM_EN, RAM_WE, BUSY, CPU_STALL, RAM_ADDR, RAM_WDATA, CPU_RDATA, LD_RDATA} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_values: got ack=%0b%0b en=%0b we=%0b busy=%0b addr=%h wd=%h crd=%h lrd=%h, required all 0",
               CPU_ACK, LD_ACK, RAM_EN, RAM_WE, BUSY, RAM_ADDR, RAM_WDATA, CPU_RDATA, LD_RDATA);
    end
  endtask

  task automatic test_cpu_write();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 8'h10; CPU_WDATA = 8'hA5;
    push(1'b0, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if ({CPU_STALL, RAM_EN} !== 2'b10) begin
      n_err++;
      $display("FAIL wr_cycle0: got stall=%0b en=%0b, required stall=1 en=0", CPU_STALL, RAM_EN);
    end
    tick();
    n_cmp++;
    if ({RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, CPU_STALL, CPU_ACK} !== {2'b11, 8'h10, 8'hA5, 2'b10}) begin
      n_err++;
      $display("FAIL wr_access: got en=%0b we=%0b addr=%h wd=%h stall=%0b ack=%0b, required 1 1 10 a5 1 0",
               RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, CPU_STALL, CPU_ACK);
    end
    tick();
    n_cmp++;
    if ({CPU_ACK, RAM_EN, RAM_WE, CPU_STALL} !== 4'b1000) begin
      n_err++;
      $display("FAIL wr_ack: got ack=%0b en=%0b we=%0b stall=%0b, required 1 0 0 0", CPU_ACK, RAM_EN, RAM_WE, CPU_STALL);
    end
    CPU_REQ = 1'b0;
    tick();
    n_cmp++;
    if ({BUSY, CPU_ACK} !== 2'b00) begin
      n_err++;
      $display("FAIL wr_idle: got busy=%0b ack=%0b, required 0 0", BUSY, CPU_ACK);
    end
  endtask

  task automatic test_cpu_read();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h10;
    push(1'b0, 1'b1, 8'hA5);
    tick();
    n_cmp++;
    if ({RAM_EN, RAM_WE, RAM_ADDR} !== {2'b10, 8'h10}) begin
      n_err++;
      $display("FAIL rd_access: got en=%0b we=%0b addr=%h, required 1 0 10", RAM_EN, RAM_WE, RAM_ADDR);
    end
    tick();
    n_cmp++;
    if ({BUSY, RAM_EN, CPU_ACK, LD_ACK} !== 4'b1000) begin
      n_err++;
      $display("FAIL rd_wait: got busy=%0b en=%0b cack=%0b lack=%0b, required 1 0 0 0", BUSY, RAM_EN, CPU_ACK, LD_ACK);
    end
    tick();
    n_cmp++;
    if ({CPU_ACK, LD_ACK, CPU_RDATA} !== {2'b10, 8'hA5}) begin
      n_err++;
      $display("FAIL rd_ack: got cack=%0b lack=%0b rdata=%h, required 1 0 a5", CPU_ACK, LD_ACK, CPU_RDATA);
    end
    CPU_REQ = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 8'h20; CPU_WDATA = 8'h11;
    LD_REQ  = 1'b1; LD_WE  = 1'b1; LD_ADDR  = 8'h30; LD_WDATA  = 8'h22;
    push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
    push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1 || c == 4) begin
        n_cmp++;
        if ({RAM_EN, RAM_ADDR} !== {1'b1, (c == 1) ? 8'h20 : 8'h30}) begin
          n_err++;
          $display("FAIL rr_addr_c%0d: got en=%0b addr=%h, required en=1 addr=%h", c, RAM_EN, RAM_ADDR, (c == 1) ? 8'h20 : 8'h30);
        end
      end
    end
    CPU_REQ = 1'b0; LD_REQ = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_pending: got %0d outstanding acks, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_lock();
    do_reset();
    LD_LOCK = 1'b1;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 8'h40; CPU_WDATA = 8'h33;
    LD_REQ  = 1'b1; LD_WE  = 1'b1; LD_ADDR  = 8'h50; LD_WDATA  = 8'h44;
    push(1'b1, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00); push(1'b0, 1'b0, 8'h00);
    for (int c = 1; c <= 5; c++) tick();
    LD_LOCK = 1'b0; LD_REQ = 1'b0;
    tick();
    n_cmp++;
    if ({BUSY, CPU_STALL} !== 2'b01) begin
      n_err++;
      $display("FAIL lock_idle: got busy=%0b stall=%0b, required 0 1", BUSY, CPU_STALL);
    end
    tick();
    n_cmp++;
    if ({RAM_EN, RAM_ADDR, RAM_WDATA} !== {1'b1, 8'h40, 8'h33}) begin
      n_err++;
      $display("FAIL lock_cpu_grant: got en=%0b addr=%h wd=%h, required 1 40 33", RAM_EN, RAM_ADDR, RAM_WDATA);
    end
    tick();
    n_cmp++;
    if (CPU_ACK !== 1'b1) begin
      n_err++;
      $display("FAIL lock_cpu_ack: got %0b, required 1", CPU_ACK);
    end
    CPU_REQ = 1'b0;
    tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL lock_pending: got %0d outstanding acks, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_latency3();
    LD_REQ3 = 1'b1; LD_WE3 = 1'b0; LD_ADDR3 = 8'h44;
    tick();
    n_cmp++;
    if ({RAM_EN3, RAM_WE3, RAM_ADDR3} !== {2'b10, 8'h44}) begin
      n_err++;
      $display("FAIL l3_access: got en=%0b we=%0b addr=%h, required 1 0 44", RAM_EN3, RAM_WE3, RAM_ADDR3);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_cmp++;
      if ({BUSY3, RAM_EN3, LD_ACK3} !== 3'b100) begin
        n_err++;
        $display("FAIL l3_wait_c%0d: got busy=%0b en=%0b ack=%0b, required 1 0 0", c, BUSY3, RAM_EN3, LD_ACK3);
      end
    end
    tick();
    n_cmp++;
    if ({LD_ACK3, CPU_ACK3, LD_RDATA3} !== {2'b10, 8'h5C}) begin
      n_err++;
      $display("FAIL l3_ack: got lack=%0b cack=%0b rdata=%h, required 1 0 5c", LD_ACK3, CPU_ACK3, LD_RDATA3);
    end
    LD_REQ3 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit got_ack;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h50;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    n_cmp++;
    if ({BUSY, CPU_ACK, LD_ACK, RAM_EN, RAM_ADDR, CPU_RDATA} !== 20'h0) begin
      n_err++;
      $display("FAIL rstmid_values: got busy=%0b ack=%0b%0b en=%0b addr=%h crd=%h, required all 0",
               BUSY, CPU_ACK, LD_ACK, RAM_EN, RAM_ADDR, CPU_RDATA);
    end
    RESET = 1'b0;
    push(1'b0, 1'b1, 8'h44);
    got_ack = 1'b0;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      tick();
      got_ack = CPU_ACK;
    end
    n_cmp++;
    if (!got_ack || CPU_RDATA !== 8'h44) begin
      n_err++;
      $display("FAIL rstmid_retry: got ack=%0b rdata=%h, required ack=1 rdata=44", got_ack, CPU_RDATA);
    end
    CPU_REQ = 1'b0;
    tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_pending: got %0d outstanding acks, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_round_robin();
    test_lock();
    test_latency3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
